cursor_move_controller: RTL and testbench

//  Turns the four raw board push-buttons into clean one-cycle step commands for the 8x8 matrix

---
 rtl/cursor_ctrl_pkg.sv | 27 ++
 rtl/key_synchronizer.sv | 21 ++
 rtl/cursor_move_controller.sv | 118 +++++++++++
 tb/tb_cursor_move_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_ctrl_pkg.sv
// Shared types for the cursor button controller: direction/state enums and key priority.
package cursor_ctrl_pkg;
  localparam int NUM_KEYS = 4;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_RIGHT = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    FIRE,
    HOLD,
    RELEASE
  } state_t;

  // Lowest key index wins when several buttons are down together.
  function automatic dir_t pick_dir(input logic [NUM_KEYS-1:0] pressed);
    pick_dir = DIR_LEFT;
    if (pressed[2]) pick_dir = DIR_RIGHT;
    if (pressed[1]) pick_dir = DIR_UP;
    if (pressed[0]) pick_dir = DIR_DOWN;
  endfunction
endpackage

// File: rtl/key_synchronizer.sv
// Two-flop synchroniser for the raw active-low buttons; resets to "released".
module key_synchronizer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      dout <= '1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end
endmodule

// File: rtl/cursor_move_controller.sv
// Debounces the four cursor buttons and emits one-cycle step pulses per press.
// Define CURSOR_AUTO_REPEAT_EN to re-fire while a button stays held.
module cursor_move_controller
  import cursor_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic                enable,
  output logic                step_down,
  output logic                step_up,
  output logic                step_right,
  output logic                step_left,
  output logic [1:0]          dir_code,
  output logic                busy
);
  localparam int MAX_P = (DEBOUNCE_CYCLES > REPEAT_DELAY)
                         ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
                         : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam int CW = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DB_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);
`ifdef CURSOR_AUTO_REPEAT_EN
  localparam cnt_t RD_LAST = cnt_t'(REPEAT_DELAY - 1);
  localparam cnt_t RP_LAST = cnt_t'(REPEAT_PERIOD - 1);
  logic rpt;
`endif

  logic [NUM_KEYS-1:0] key_sync;
  logic [NUM_KEYS-1:0] pressed;
  state_t              state;
  dir_t                dir;
  cnt_t                cnt;
  cnt_t                cnt_inc;
  logic                key_held;

  key_synchronizer #(.WIDTH(NUM_KEYS)) u_sync (
    .clock (clock),
    .reset (reset),
    .din   (key_n),
    .dout  (key_sync)
  );

  assign pressed  = ~key_sync;
  assign key_held = pressed[dir];
  assign cnt_inc  = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      dir   <= DIR_DOWN;
      cnt   <= '0;
`ifdef CURSOR_AUTO_REPEAT_EN
      rpt   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (enable && |pressed) begin
            dir   <= pick_dir(pressed);
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!key_held || !enable) begin
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
            if (cnt == DB_LAST) state <= FIRE;
          end
        end
        FIRE: begin
          cnt   <= '0;
          state <= HOLD;
        end
        HOLD: begin
          if (!key_held || !enable) begin
            cnt   <= '0;
            state <= RELEASE;
          end else begin
            cnt <= cnt_inc;
`ifdef CURSOR_AUTO_REPEAT_EN
            // Compare the advanced count so the FIRE cycle is part of the repeat spacing.
            if (cnt_inc == (rpt ? RP_LAST : RD_LAST)) begin
              rpt   <= 1'b1;
              state <= FIRE;
            end
`endif
          end
        end
        RELEASE: begin
`ifdef CURSOR_AUTO_REPEAT_EN
          rpt <= 1'b0;
`endif
          if (key_held) begin
            cnt <= '0;
          end else begin
            cnt <= cnt_inc;
            if (cnt == DB_LAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign step_down  = (state == FIRE) && (dir == DIR_DOWN);
  assign step_up    = (state == FIRE) && (dir == DIR_UP);
  assign step_right = (state == FIRE) && (dir == DIR_RIGHT);
  assign step_left  = (state == FIRE) && (dir == DIR_LEFT);
  assign dir_code   = dir;
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_cursor_move_controller.sv
// Scoreboarded bench for cursor_move_controller with short debounce/repeat parameters.
module tb_cursor_move_controller;
  logic       clock  = 1'b0;
  logic       reset  = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] key_n  = 4'hF;
  logic       step_down, step_up, step_right, step_left, busy;
  logic [1:0] dir_code;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int         exp_cyc[$];
  logic [3:0] exp_mask[$];

  cursor_move_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_n      (key_n),
    .enable     (enable),
    .step_down  (step_down),
    .step_up    (step_up),
    .step_right (step_right),
    .step_left  (step_left),
    .dir_code   (dir_code),
    .busy       (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Pulse monitor: every observed step pulse is matched against the next expected one.
  always @(negedge clock) begin
    logic [3:0] m;
    int         ec;
    logic [3:0] em;
    m = {step_left, step_right, step_up, step_down};
    if (m != 4'd0) begin
      total++;
      if (exp_cyc.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected: got mask=%b at cycle %0d, required no pulse", m, cyc);
      end else begin
        ec = exp_cyc.pop_front();
        em = exp_mask.pop_front();
        if (m !== em || cyc != ec) begin
          bad++;
          $display("FAIL pulse: got mask=%b cycle=%0d, required mask=%b cycle=%0d", m, cyc, em, ec);
        end
      end
    end
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic push_exp(input int c, input logic [3:0] m);
    exp_cyc.push_back(c);
    exp_mask.push_back(m);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    total++;
    if ({step_left, step_right, step_up, step_down} !== 4'b0000) begin
      bad++; $display("FAIL reset_steps: got %b, required 0000", {step_left, step_right, step_up, step_down});
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    total++;
    if (dir_code !== 2'd0) begin bad++; $display("FAIL reset_dir: got %0d, required 0", dir_code); end
    reset = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_single();
    int t0;
    t0 = cyc;
    key_n = 4'b1110;
    push_exp(t0 + 7, 4'b0001);
`ifdef CURSOR_AUTO_REPEAT_EN
    for (int k = 17; k <= 29; k += 3) push_exp(t0 + k, 4'b0001);
`endif
    goto(t0 + 2);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_e2: got %b, required 0", busy); end
    goto(t0 + 3);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_e3: got %b, required 1", busy); end
    goto(t0 + 8);
    total++;
    if (dir_code !== 2'd0) begin bad++; $display("FAIL single_dir: got %0d, required 0", dir_code); end
    goto(t0 + 29);
    key_n = 4'hF;
    goto(t0 + 35);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_release: got %b, required 1", busy); end
    goto(t0 + 36);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_idle: got %b, required 0", busy); end
    total++;
    if (exp_cyc.size() != 0) begin bad++; $display("FAIL single_missing: got %0d pulses outstanding, required 0", exp_cyc.size()); end
    exp_cyc.delete(); exp_mask.delete();
  endtask

  task automatic test_bounce();
    int t0;
    t0 = cyc;
    for (int r = 0; r < 6; r++) begin
      key_n = 4'b1011;
      goto(t0 + 3*r + 2);
      key_n = 4'hF;
      goto(t0 + 3*r + 3);
    end
    goto(t0 + 22);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL bounce_busy: got %b, required 0", busy); end
    total++;
    if (dir_code !== 2'd2) begin bad++; $display("FAIL bounce_dir: got %0d, required 2", dir_code); end
    total++;
    if (exp_cyc.size() != 0) begin bad++; $display("FAIL bounce_missing: got %0d outstanding, required 0", exp_cyc.size()); end
    exp_cyc.delete(); exp_mask.delete();
  endtask

  task automatic test_two_keys();
    int t0;
    t0 = cyc;
    key_n = 4'b0110;
    push_exp(t0 + 7, 4'b0001);
    push_exp(t0 + 24, 4'b1000);
    goto(t0 + 8);
    total++;
    if (dir_code !== 2'd0) begin bad++; $display("FAIL two_dir_down: got %0d, required 0", dir_code); end
    goto(t0 + 12);
    key_n = 4'b0111;
    goto(t0 + 19);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL two_rearb_idle: got %b, required 0", busy); end
    goto(t0 + 25);
    total++;
    if (dir_code !== 2'd3) begin bad++; $display("FAIL two_dir_left: got %0d, required 3", dir_code); end
    goto(t0 + 30);
    key_n = 4'hF;
    goto(t0 + 38);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL two_busy_end: got %b, required 0", busy); end
    total++;
    if (exp_cyc.size() != 0) begin bad++; $display("FAIL two_missing: got %0d outstanding, required 0", exp_cyc.size()); end
    exp_cyc.delete(); exp_mask.delete();
  endtask

  task automatic test_reset_mid();
    int t0;
    t0 = cyc;
    key_n = 4'b1101;
    push_exp(t0 + 12, 4'b0010);
    goto(t0 + 4);
    total++;
    if (busy !== 1'b1 || dir_code !== 2'd1) begin
      bad++; $display("FAIL midrst_pre: got busy=%b dir=%0d, required busy=1 dir=1", busy, dir_code);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({busy, dir_code, step_left, step_right, step_up, step_down} !== 7'd0) begin
      bad++; $display("FAIL midrst_outputs: got busy=%b dir=%0d, required all 0", busy, dir_code);
    end
    goto(t0 + 5);
    reset = 1'b1;
    goto(t0 + 7);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_resync: got %b, required 0", busy); end
    goto(t0 + 15);
    key_n = 4'hF;
    goto(t0 + 23);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_end: got %b, required 0", busy); end
    total++;
    if (exp_cyc.size() != 0) begin bad++; $display("FAIL midrst_missing: got %0d outstanding, required 0", exp_cyc.size()); end
    exp_cyc.delete(); exp_mask.delete();
  endtask

  task automatic test_enable();
    int t0;
    t0 = cyc;
    enable = 1'b0;
    key_n  = 4'b1011;
    goto(t0 + 6);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL en_off_busy: got %b, required 0", busy); end
    goto(t0 + 12);
    key_n = 4'hF;
    goto(t0 + 16);
    enable = 1'b1;
    t0 = cyc;
    key_n = 4'b1011;
    push_exp(t0 + 7, 4'b0100);
    goto(t0 + 11);
    enable = 1'b0;
    goto(t0 + 20);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL en_release_busy: got %b, required 1", busy); end
    goto(t0 + 25);
    key_n = 4'hF;
    goto(t0 + 30);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL en_release_count: got %b, required 1", busy); end
    goto(t0 + 31);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL en_idle: got %b, required 0", busy); end
    total++;
    if (dir_code !== 2'd2) begin bad++; $display("FAIL en_dir: got %0d, required 2", dir_code); end
    enable = 1'b1;
    total++;
    if (exp_cyc.size() != 0) begin bad++; $display("FAIL en_missing: got %0d outstanding, required 0", exp_cyc.size()); end
    exp_cyc.delete(); exp_mask.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_bounce();
    test_two_keys();
    test_reset_mid();
    test_enable();
    repeat (4) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
